btb_update_queue: RTL

Buffers resolved-branch target updates from the two branch execution units and drains them one per cycle into the branch target buffer's update port. Drops duplicate updates for the same branch source address, and drops updates on overflow, because BTB updates are hints. Sits between the branch units (upstream) and the BTB write port (downstream). It never back-pressures the execute pipeline.

---
 rtl/btb_update_queue_pkg.sv | 25 ++
 rtl/btb_update_queue.sv | 91 +++++++++
 2 files changed

// File: rtl/btb_update_queue_pkg.sv
// Shared BTB update packet definitions used by the branch units, the BTB and the update queue.
package btb_update_queue_pkg;

    localparam int PC_W = 31;

    typedef struct packed {
        logic [PC_W-1:0] src;
        logic            rsv35;
        logic [PC_W-1:0] dst;
        logic            rsv3;
        logic            isJump;
        logic            compr;
        logic            valid;
    } BTUpdate;

    // Reserved bits are never trusted from the producers; clear them before storage.
    function automatic BTUpdate scrub_upd(input BTUpdate p);
        BTUpdate q;
        q       = p;
        q.rsv3  = 1'b0;
        q.rsv35 = 1'b0;
        return q;
    endfunction

endpackage

// File: rtl/btb_update_queue.sv
// Buffers BTB target updates from two branch units, filters duplicate sources,
// and drains one update per cycle to the BTB write port. Never back-pressures.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [66:0] IN_upd0,
    input  logic [66:0] IN_upd1,
    output logic [66:0] OUT_btUpdate,
    output logic [7:0]  OUT_dropCnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    BTUpdate        r_mem [DEPTH];
    BTUpdate        r_out;
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [CW-1:0]  r_count;
    logic [7:0]     r_drop;

    BTUpdate        w_u0;
    BTUpdate        w_u1;
    logic           w_dup0;
    logic           w_dup1;
    logic           w_keep0;
    logic           w_keep1;
    logic           w_pop;
    logic [CW-1:0]  w_free;
    logic           w_push0;
    logic           w_push1;
    logic [1:0]     w_npush;
    logic [1:0]     w_drops;
    logic [8:0]     w_dsum;

    assign w_u0 = IN_upd0;
    assign w_u1 = IN_upd1;

    // Live entries are those within count of the read pointer, head included.
    always_comb begin
        w_dup0 = r_out.valid && (r_out.src == w_u0.src);
        w_dup1 = (r_out.valid && (r_out.src == w_u1.src)) ||
                 (w_u0.valid && (w_u0.src == w_u1.src));
        for (int j = 0; j < DEPTH; j++) begin
            if ({1'b0, PW'(j) - r_rd} < r_count) begin
                if (r_mem[j].src == w_u0.src) w_dup0 = 1'b1;
                if (r_mem[j].src == w_u1.src) w_dup1 = 1'b1;
            end
        end
    end

    assign w_keep0 = w_u0.valid && !w_dup0;
    assign w_keep1 = w_u1.valid && !w_dup1;
    assign w_pop   = (r_count != '0);
    assign w_free  = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_push0 = w_keep0 && (w_free != '0);
    assign w_push1 = w_keep1 && (w_free > CW'(w_push0));
    assign w_npush = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_drops = {1'b0, w_keep0 && !w_push0} + {1'b0, w_keep1 && !w_push1};
    assign w_dsum  = {1'b0, r_drop} + {7'b0, w_drops};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_drop  <= '0;
        end else begin
            if (w_pop) begin
                r_out <= r_mem[r_rd];
                r_rd  <= r_rd + PW'(1);
            end else begin
                r_out.valid <= 1'b0;
            end
            if (w_push0) r_mem[r_wr] <= scrub_upd(w_u0);
            if (w_push1) r_mem[r_wr + PW'(w_push0)] <= scrub_upd(w_u1);
            r_wr    <= r_wr + PW'(w_npush);
            r_count <= r_count + CW'(w_npush) - CW'(w_pop);
            r_drop  <= w_dsum[8] ? 8'hFF : w_dsum[7:0];
        end
    end

    assign OUT_btUpdate = r_out;
    assign OUT_dropCnt  = r_drop;

endmodule
